// File: rtl/multiplicador_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Holds the control state encoding used by the FSM and the datapath.
package multiplicador_pkg;

    localparam int ESTADO_W = 3;

    typedef enum logic [ESTADO_W-1:0] {
        ESPERA    = 3'd0,
        CARGAR    = 3'd1,
        SUMAR     = 3'd2,
        DESPLAZAR = 3'd3,
        FIN       = 3'd4
    } estado_t;

endpackage

// File: rtl/multiplicador_secuencial_if.sv
// start/busy/done handshake and operand/result bus of the sequential multiplier.
// master drives the request; slave is the multiplier itself.
interface multiplicador_secuencial_if #(
    parameter int W = 8
);
    logic           start;
    logic [W-1:0]   multiplicando;
    logic [W-1:0]   multiplicador;
    logic [2*W-1:0] producto;
    logic           ocupado;
    logic           done;

    modport master (
        output start, multiplicando, multiplicador,
        input  producto, ocupado, done
    );

    modport slave (
        input  start, multiplicando, multiplicador,
        output producto, ocupado, done
    );
endinterface

// File: rtl/multiplicador_control.sv
// Control FSM of the shift-and-add multiplier: one add/shift pair per operand bit.
// Outputs are decoded from the state; only aceptar also depends on start.
module multiplicador_control
    import multiplicador_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic q0,
    input  logic ultimo,
    output logic aceptar,
    output logic cargar,
    output logic sumar,
    output logic desplazar,
    output logic fin,
    output logic ocupado
);

    estado_t estado, siguiente;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) estado <= ESPERA;
        else      estado <= siguiente;
    end

    always_comb begin
        siguiente = ESPERA;
        aceptar   = 1'b0;
        cargar    = 1'b0;
        sumar     = 1'b0;
        desplazar = 1'b0;
        fin       = 1'b0;
        ocupado   = 1'b0;
        case (estado)
            ESPERA: begin
                if (start) begin
                    aceptar   = 1'b1;
                    siguiente = CARGAR;
                end
            end
            CARGAR: begin
                cargar    = 1'b1;
                ocupado   = 1'b1;
                siguiente = SUMAR;
            end
            SUMAR: begin
                sumar     = q0;
                ocupado   = 1'b1;
                siguiente = DESPLAZAR;
            end
            DESPLAZAR: begin
                desplazar = 1'b1;
                ocupado   = 1'b1;
                siguiente = ultimo ? FIN : SUMAR;
            end
            FIN: begin
                fin       = 1'b1;
                ocupado   = 1'b1;
                siguiente = ESPERA;
            end
            default: siguiente = ESPERA;
        endcase
    end

endmodule

// File: rtl/multiplicador_secuencial.sv
// Sequential unsigned W x W -> 2W multiplier: accumulator, multiplier shift
// register and bit counter, sequenced by multiplicador_control.
module multiplicador_secuencial
    import multiplicador_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    multiplicador_secuencial_if.slave   bus
);

    localparam int CONT_W = $clog2(W + 1);

    logic [W-1:0]      acc, q, a_reg;
    logic              carry;
    logic [CONT_W-1:0] contador;
    logic [2*W-1:0]    producto;
    logic [W:0]        suma;
    logic              aceptar, cargar, sumar, desplazar, fin, ocupado, ultimo;

    assign suma   = {1'b0, acc} + {1'b0, a_reg};
    assign ultimo = (contador == CONT_W'(1));

    multiplicador_control u_control (
        .clk       (clk),
        .rst       (rst),
        .start     (bus.start),
        .q0        (q[0]),
        .ultimo    (ultimo),
        .aceptar   (aceptar),
        .cargar    (cargar),
        .sumar     (sumar),
        .desplazar (desplazar),
        .fin       (fin),
        .ocupado   (ocupado)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            q        <= '0;
            a_reg    <= '0;
            carry    <= 1'b0;
            contador <= '0;
            producto <= '0;
        end else begin
            if (aceptar) begin
                a_reg <= bus.multiplicando;
                q     <= bus.multiplicador;
                acc   <= '0;
                carry <= 1'b0;
            end
            if (cargar) contador <= CONT_W'(W);
            if (sumar) {carry, acc} <= suma;
            // The carry re-enters at the top of acc, so no product bit is lost.
            if (desplazar) begin
                {carry, acc, q} <= {1'b0, carry, acc, q[W-1:1]};
                contador        <= contador - CONT_W'(1);
                if (ultimo) producto <= {carry, acc, q[W-1:1]};
            end
        end
    end

    assign bus.producto = producto;
    assign bus.ocupado  = ocupado;
    assign bus.done     = fin;

endmodule
